// File: rtl/ulpi_pkg.sv
// Shared ULPI definitions: responder states, TX CMD codes, register map and defaults.
// Also imported by the link-side sequencer so both ends agree on addresses.
package ulpi_pkg;

    typedef enum logic [3:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_RD_ACK,
        ST_RD_TA1,
        ST_RD_DATA,
        ST_RD_TA2,
        ST_WR_ACK,
        ST_WR_DATA,
        ST_WR_STP
    } phy_state_e;

    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_TX   = 2'b01;
    localparam logic [1:0] CMD_REGW = 2'b10;
    localparam logic [1:0] CMD_REGR = 2'b11;

    localparam logic [5:0] EXT_ADDR = 6'h2F;

    localparam logic [5:0] ADDR_VENDOR_ID_LOW   = 6'h00;
    localparam logic [5:0] ADDR_VENDOR_ID_HIGH  = 6'h01;
    localparam logic [5:0] ADDR_PRODUCT_ID_LOW  = 6'h02;
    localparam logic [5:0] ADDR_PRODUCT_ID_HIGH = 6'h03;
    localparam logic [5:0] ADDR_FUNC_CTRL       = 6'h04;
    localparam logic [5:0] ADDR_IFC_CTRL        = 6'h07;
    localparam logic [5:0] ADDR_OTG_CTRL        = 6'h0A;
    localparam logic [5:0] ADDR_INT_EN_RISE     = 6'h0D;
    localparam logic [5:0] ADDR_INT_EN_FALL     = 6'h10;
    localparam logic [5:0] ADDR_SCRATCH         = 6'h16;

    localparam logic [7:0] VENDOR_ID_LOW   = 8'h24;
    localparam logic [7:0] VENDOR_ID_HIGH  = 8'h04;
    localparam logic [7:0] PRODUCT_ID_LOW  = 8'h04;
    localparam logic [7:0] PRODUCT_ID_HIGH = 8'h00;

    localparam int NUM_RW     = 5;
    localparam int ALIAS_BASE = 4;

    // Entry k is the default of the RW register at ALIAS_BASE + 3*k.
    localparam logic [NUM_RW-1:0][7:0] RW_DEFAULTS = {8'h1F, 8'h1F, 8'h06, 8'h00, 8'h41};
    localparam logic [7:0] SCRATCH_DEFAULT = 8'h00;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_SET   = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
        logic [1:0] op;
    } alias_dec_t;

    function automatic alias_dec_t alias_decode(input logic [5:0] addr);
        alias_dec_t dec;
        dec = '0;
        for (int k = 0; k < NUM_RW; k++) begin
            for (int o = 0; o < 3; o++) begin
                if (addr == 6'(ALIAS_BASE + 3 * k + o)) begin
                    dec.hit = 1'b1;
                    dec.idx = 3'(k);
                    dec.op  = 2'(o);
                end
            end
        end
        return dec;
    endfunction

endpackage

// File: rtl/ulpi_phy_regfile.sv
// USB3300-style register file behind the responder: read mux plus write/set/clear
// aliases. Reads are combinational; a write lands on the commit edge.
module ulpi_phy_regfile
    import ulpi_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_value,
    output logic       wr_hit,
    output logic [7:0] wr_result
);

    logic [7:0] rw_regs [NUM_RW];
    logic [7:0] scratch;
    alias_dec_t rd_dec;
    alias_dec_t wr_dec;
    logic [7:0] wr_current;

    always_comb begin
        rd_dec  = alias_decode(rd_addr);
        rd_data = 8'h00;
        case (rd_addr)
            ADDR_VENDOR_ID_LOW:   rd_data = VENDOR_ID_LOW;
            ADDR_VENDOR_ID_HIGH:  rd_data = VENDOR_ID_HIGH;
            ADDR_PRODUCT_ID_LOW:  rd_data = PRODUCT_ID_LOW;
            ADDR_PRODUCT_ID_HIGH: rd_data = PRODUCT_ID_HIGH;
            ADDR_SCRATCH:         rd_data = scratch;
            default: begin
                if (rd_dec.hit) begin
                    rd_data = rw_regs[rd_dec.idx];
                end
            end
        endcase
    end

    // wr_result is the post-commit value, so the responder can report it directly.
    always_comb begin
        wr_dec     = alias_decode(wr_addr);
        wr_hit     = 1'b0;
        wr_current = 8'h00;
        wr_result  = 8'h00;
        if (wr_dec.hit) begin
            wr_hit     = 1'b1;
            wr_current = rw_regs[wr_dec.idx];
            case (wr_dec.op)
                OP_WRITE: wr_result = wr_value;
                OP_SET:   wr_result = wr_current | wr_value;
                default:  wr_result = wr_current & ~wr_value;
            endcase
        end else if (wr_addr == ADDR_SCRATCH) begin
            wr_hit    = 1'b1;
            wr_result = wr_value;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_RW; k++) begin
                rw_regs[k] <= RW_DEFAULTS[k];
            end
            scratch <= SCRATCH_DEFAULT;
        end else if (wr_en && wr_hit) begin
            if (wr_dec.hit) begin
                rw_regs[wr_dec.idx] <= wr_result;
            end else begin
                scratch <= wr_result;
            end
        end
    end

endmodule

// File: rtl/ulpi_phy_responder.sv
// PHY-side ULPI register responder: answers link TX CMD reads/writes with DIR/NXT
// handshaking and turnarounds, backed by ulpi_phy_regfile.
//
//   state      | meaning
//   STARTUP    | dir held high, emulating PHY PLL start-up
//   IDLE       | bus owned by link, decoding TX CMD
//   RD_ACK     | nxt high, read command accepted
//   RD_TA1     | dir rises, turnaround to PHY
//   RD_DATA    | PHY drives register value
//   RD_TA2     | dir falls, turnaround to link
//   WR_ACK     | nxt high, write command accepted
//   WR_DATA    | nxt high, data byte captured
//   WR_STP     | waiting for stp to commit
module ulpi_phy_responder
    import ulpi_pkg::*;
#(
    parameter int STARTUP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       dir,
    output logic       nxt,
    input  logic       stp,
    output logic       wr_strobe,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       cmd_err
);

    localparam int CNT_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STARTUP_CYCLES - 1);

    phy_state_e       state;
    phy_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       addr;
    logic [7:0]       hold;
    logic             cmd_bad;
    logic             commit;
    logic [7:0]       rd_data;
    logic             wr_hit;
    logic [7:0]       wr_result;

    ulpi_phy_regfile u_regfile (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (addr),
        .rd_data   (rd_data),
        .wr_en     (commit),
        .wr_addr   (addr),
        .wr_value  (hold),
        .wr_hit    (wr_hit),
        .wr_result (wr_result)
    );

    assign commit = (state == ST_WR_STP) && stp;

    always_comb begin
        state_next = state;
        cmd_bad    = 1'b0;
        case (state)
            ST_STARTUP: begin
                if (cnt == '0) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (data_in != 8'h00) begin
                    if (data_in[7:6] == CMD_REGR && data_in[5:0] != EXT_ADDR) begin
                        state_next = ST_RD_ACK;
                    end else if (data_in[7:6] == CMD_REGW && data_in[5:0] != EXT_ADDR) begin
                        state_next = ST_WR_ACK;
                    end else begin
                        cmd_bad = 1'b1;
                    end
                end
            end
            ST_RD_ACK:  state_next = ST_RD_TA1;
            ST_RD_TA1:  state_next = ST_RD_DATA;
            ST_RD_DATA: state_next = ST_RD_TA2;
            ST_RD_TA2:  state_next = ST_IDLE;
            ST_WR_ACK:  state_next = ST_WR_DATA;
            ST_WR_DATA: state_next = ST_WR_STP;
            ST_WR_STP: begin
                if (stp) begin
                    state_next = ST_IDLE;
                end
            end
            default:    state_next = ST_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they are flop outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_STARTUP;
            cnt       <= CNT_LOAD;
            addr      <= 6'h00;
            hold      <= 8'h00;
            dir       <= 1'b1;
            nxt       <= 1'b0;
            data_oe   <= 1'b0;
            data_out  <= 8'h00;
            wr_strobe <= 1'b0;
            wr_addr   <= 6'h00;
            wr_data   <= 8'h00;
            cmd_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_STARTUP && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == ST_IDLE) begin
                addr <= data_in[5:0];
            end
            if (state == ST_WR_DATA) begin
                hold <= data_in;
            end
            dir       <= (state_next == ST_STARTUP) || (state_next == ST_RD_TA1) ||
                         (state_next == ST_RD_DATA);
            nxt       <= (state_next == ST_RD_ACK) || (state_next == ST_WR_ACK) ||
                         (state_next == ST_WR_DATA);
            data_oe   <= (state_next == ST_RD_DATA);
            data_out  <= (state_next == ST_RD_DATA) ? rd_data : 8'h00;
            wr_strobe <= commit && wr_hit;
            cmd_err   <= cmd_bad;
            if (commit && wr_hit) begin
                wr_addr <= addr;
                wr_data <= wr_result;
            end
        end
    end

endmodule

// File: tb/tb_ulpi_phy_responder.sv
// Directed bench for ulpi_phy_responder: start-up, reads, write/set/clear aliases,
// bad commands and asynchronous reset in mid-transaction.
module tb_ulpi_phy_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       dir;
    logic       nxt;
    logic       stp;
    logic       wr_strobe;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       cmd_err;

    int checks = 0;
    int errors = 0;

    ulpi_phy_responder #(.STARTUP_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .dir       (dir),
        .nxt       (nxt),
        .stp       (stp),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic do_read(input logic [7:0] cmd, input logic [7:0] exp, input string name);
        data_in = cmd;
        @(posedge clk); #1;
        data_in = 8'h00;
        checks++;
        if (nxt !== 1'b1 || dir !== 1'b0 || data_oe !== 1'b0) begin
            errors++;
            $display("FAIL %s ack: nxt=%b dir=%b oe=%b required 1 0 0", name, nxt, dir, data_oe);
        end
        @(posedge clk); #1;
        checks++;
        if (nxt !== 1'b0 || dir !== 1'b1 || data_oe !== 1'b0) begin
            errors++;
            $display("FAIL %s ta1: nxt=%b dir=%b oe=%b required 0 1 0", name, nxt, dir, data_oe);
        end
        @(posedge clk); #1;
        checks++;
        if (data_oe !== 1'b1 || dir !== 1'b1 || data_out !== exp) begin
            errors++;
            $display("FAIL %s data: oe=%b dir=%b data_out=%h required 1 1 %h",
                     name, data_oe, dir, data_out, exp);
        end
        @(posedge clk); #1;
        checks++;
        if (dir !== 1'b0 || data_oe !== 1'b0 || nxt !== 1'b0) begin
            errors++;
            $display("FAIL %s ta2: dir=%b oe=%b nxt=%b required 0 0 0", name, dir, data_oe, nxt);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [7:0] data,
                            input logic strobe_exp, input logic [7:0] val_exp,
                            input string name);
        logic [5:0] addr_exp;
        addr_exp = cmd[5:0];
        data_in  = cmd;
        @(posedge clk); #1;
        data_in = data;
        checks++;
        if (nxt !== 1'b1 || dir !== 1'b0) begin
            errors++;
            $display("FAIL %s ack: nxt=%b dir=%b required 1 0", name, nxt, dir);
        end
        @(posedge clk); #1;
        checks++;
        if (nxt !== 1'b1) begin
            errors++;
            $display("FAIL %s data nxt: nxt=%b required 1", name, nxt);
        end
        @(posedge clk); #1;
        data_in = 8'h00;
        @(posedge clk); #1;
        checks++;
        if (nxt !== 1'b0 || dir !== 1'b0 || wr_strobe !== 1'b0) begin
            errors++;
            $display("FAIL %s stp wait: nxt=%b dir=%b strobe=%b required 0 0 0",
                     name, nxt, dir, wr_strobe);
        end
        stp = 1'b1;
        @(posedge clk); #1;
        stp = 1'b0;
        checks++;
        if (wr_strobe !== strobe_exp) begin
            errors++;
            $display("FAIL %s strobe: wr_strobe=%b required %b", name, wr_strobe, strobe_exp);
        end
        if (strobe_exp) begin
            checks++;
            if (wr_addr !== addr_exp || wr_data !== val_exp) begin
                errors++;
                $display("FAIL %s commit: wr_addr=%h wr_data=%h required %h %h",
                         name, wr_addr, wr_data, addr_exp, val_exp);
            end
        end
    endtask

    task automatic restart(input string name);
        #1;
        checks++;
        if (dir !== 1'b1 || data_oe !== 1'b0 || nxt !== 1'b0 || wr_strobe !== 1'b0) begin
            errors++;
            $display("FAIL %s async reset: dir=%b oe=%b nxt=%b strobe=%b required 1 0 0 0",
                     name, dir, data_oe, nxt, wr_strobe);
        end
        stp     = 1'b0;
        data_in = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (dir !== 1'b1) begin
            errors++;
            $display("FAIL %s startup hold: dir=%b required 1", name, dir);
        end
        @(posedge clk); #1;
        checks++;
        if (dir !== 1'b0) begin
            errors++;
            $display("FAIL %s startup end: dir=%b required 0", name, dir);
        end
    endtask

    task automatic test_reset();
        logic exp_dir;
        reset   = 1'b1;
        data_in = 8'h00;
        stp     = 1'b0;
        #1 reset = 1'b0;
        #1;
        checks++;
        if (dir !== 1'b1 || nxt !== 1'b0 || data_oe !== 1'b0 || data_out !== 8'h00 ||
            wr_strobe !== 1'b0 || wr_addr !== 6'h00 || wr_data !== 8'h00 || cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL reset values: dir=%b nxt=%b oe=%b do=%h st=%b wa=%h wd=%h ce=%b required 1 0 0 00 0 00 00 0",
                     dir, nxt, data_oe, data_out, wr_strobe, wr_addr, wr_data, cmd_err);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            exp_dir = (i < 16);
            checks++;
            if (dir !== exp_dir || nxt !== 1'b0) begin
                errors++;
                $display("FAIL startup cycle %0d: dir=%b nxt=%b required %b 0", i, dir, nxt, exp_dir);
            end
        end
    endtask

    task automatic test_read_ro();
        do_read(8'hC0, 8'h24, "read 00");
        do_read(8'hC1, 8'h04, "read 01");
    endtask

    task automatic test_write();
        do_write(8'h8A, 8'h00, 1'b1, 8'h00, "write 0A");
        do_read(8'hCA, 8'h00, "read 0A after write");
    endtask

    task automatic test_set_clear();
        do_write(8'h85, 8'h04, 1'b1, 8'h45, "set 05");
        do_write(8'h86, 8'h01, 1'b1, 8'h44, "clear 06");
        do_read(8'hC4, 8'h44, "read 04");
        do_write(8'h92, 8'h0F, 1'b1, 8'h10, "clear 12");
        do_read(8'hD0, 8'h10, "read 10");
    endtask

    task automatic test_scratch_ignored();
        do_write(8'h96, 8'hA5, 1'b1, 8'hA5, "write scratch");
        stp = 1'b1;
        do_read(8'hD6, 8'hA5, "read scratch stp high");
        stp = 1'b0;
        do_write(8'h81, 8'hFF, 1'b0, 8'h00, "write ro 01");
        do_read(8'hC1, 8'h04, "read 01 after ro write");
        do_write(8'h9F, 8'h77, 1'b0, 8'h00, "write unmapped 1F");
        do_read(8'hDF, 8'h00, "read unmapped 1F");
    endtask

    task automatic test_cmd_err();
        logic [7:0] cmds [3];
        cmds = '{8'h40, 8'hEF, 8'h01};
        for (int i = 0; i < 3; i++) begin
            data_in = cmds[i];
            @(posedge clk); #1;
            data_in = 8'h00;
            checks++;
            if (cmd_err !== 1'b1 || nxt !== 1'b0 || dir !== 1'b0) begin
                errors++;
                $display("FAIL cmd_err %h: cmd_err=%b nxt=%b dir=%b required 1 0 0",
                         cmds[i], cmd_err, nxt, dir);
            end
            @(posedge clk); #1;
            checks++;
            if (cmd_err !== 1'b0 || nxt !== 1'b0) begin
                errors++;
                $display("FAIL cmd_err %h pulse end: cmd_err=%b nxt=%b required 0 0",
                         cmds[i], cmd_err, nxt);
            end
        end
        do_read(8'hC4, 8'h44, "read 04 after bad cmds");
        do_read(8'hCA, 8'h00, "read 0A after bad cmds");
    endtask

    task automatic test_reset_mid_read();
        data_in = 8'hCA;
        @(posedge clk); #1;
        data_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (data_oe !== 1'b1) begin
            errors++;
            $display("FAIL mid read setup: oe=%b required 1", data_oe);
        end
        reset = 1'b0;
        restart("mid read");
        do_read(8'hCA, 8'h06, "read 0A after mid-read reset");
    endtask

    task automatic test_reset_mid_write();
        do_write(8'h8A, 8'h55, 1'b1, 8'h55, "write 0A before reset");
        data_in = 8'h8A;
        @(posedge clk); #1;
        data_in = 8'h33;
        @(posedge clk); #1;
        @(posedge clk); #1;
        data_in = 8'h00;
        @(posedge clk); #1;
        reset = 1'b0;
        stp   = 1'b1;
        restart("mid write");
        do_read(8'hCA, 8'h06, "read 0A after mid-write reset");
    endtask

    initial begin
        test_reset();
        test_read_ro();
        test_write();
        test_set_clear();
        test_scratch_ignored();
        test_cmd_err();
        test_reset_mid_read();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ulpi_phy_responder.md
# ulpi_phy_responder

Synthesizable PHY-side ULPI register responder: the opposite end of our link-side ULPI register read/write sequencer. It answers link TX CMD register reads and writes over the 8-bit ULPI bus with correct DIR/NXT/STP handshaking and bus turnarounds. It backs a small USB3300-compatible register file. It is used as an in-fabric loopback target and bench model, so the link FSM can be exercised without the external PHY.

## Interface
Parameters:
- STARTUP_CYCLES, 16: cycles DIR is held high after reset, emulating PHY PLL start-up.

Ports:
- clk  in  1  ULPI clock (60 MHz domain).
- reset  in  1  asynchronous, active-low.
- data_in  in  8  bus value driven by link while dir=0.
- data_out  out  8  bus value driven by PHY; valid when data_oe=1.
- data_oe  out  1  PHY drives bus.
- dir  out  1  ULPI DIR.
- nxt  out  1  ULPI NXT.
- stp  in  1  ULPI STP from link.
- wr_strobe  out  1  one-cycle pulse on register commit.
- wr_addr  out  6  committed address (as issued, incl. set/clear alias).
- wr_data  out  8  resulting register value after commit.
- cmd_err  out  1  one-cycle pulse on unsupported TX CMD.

## Operation
- Reset values: dir=1, nxt=0, data_oe=0, data_out=0x00, wr_strobe=0, wr_addr=0, wr_data=0, cmd_err=0; state STARTUP; register file to defaults.
- Register map:
  - Read-only: 0x00=0x24, 0x01=0x04, 0x02=0x04, 0x03=0x00.
  - Five RW registers at base 0x04+3k, k=0..4, defaults 0x41, 0x00, 0x06, 0x1F, 0x1F.
  - 0x16: scratch, default 0x00.
  - All others read 0x00; writes ignored, no strobe.
- Alias decode for 0x04..0x12: idx=(addr-4)/3, op=(addr-4)%3.
  - op 0 write: reg=d. op 1 set: reg|=d. op 2 clear: reg&=~d.
  - Reads of any alias return reg[idx].
  - Writes to read-only IDs are ignored, no strobe.
- States and transitions:
  - STARTUP: dir=1 for STARTUP_CYCLES, then dir=0 → IDLE.
  - IDLE: dir=0, nxt=0. data_in[7:6] selects the action:
    - 2'b11 with addr≠0x2F → RD_ACK.
    - 2'b10 with addr≠0x2F → WR_ACK.
    - 0x00 → stay in IDLE.
    - Anything else (01xxxxxx, 00 non-zero, extended address 0x2F) → cmd_err pulse, stay in IDLE, nxt stays 0.
  - Read path: RD_ACK (nxt=1) → RD_TA1 (nxt=0, dir=1, data_oe=0) → RD_DATA (data_oe=1, data_out=reg) → RD_TA2 (dir=0, data_oe=0, data_in ignored) → IDLE.
  - Write path: WR_ACK (nxt=1) → WR_DATA (nxt=1, sample data_in into hold register) → WR_STP (nxt=0).
  - WR_STP waits indefinitely for stp=1. On stp=1: commit, pulse wr_strobe, → IDLE.
- stp is ignored in every state except WR_STP.
- A mid-write reset discards the held data; the register keeps its default.
- Reset asserted in any state: all outputs and registers return to reset values immediately (asynchronous). STARTUP replays.

## Timing
- All outputs are registered and change only on posedge clk, except on async reset.
- Read, command sampled at edge E0:
  - after E0: nxt=1.
  - after E1: dir=1, nxt=0.
  - after E2: data_oe=1, data_out valid for exactly one cycle.
  - after E3: dir=0.
  - next command sampled at E5 at the earliest.
- Write, command sampled at E0:
  - after E0 and after E1: nxt=1.
  - data byte sampled at E2.
  - commit at first edge ≥E3 with stp=1; wr_strobe/wr_addr/wr_data valid the cycle after that edge.
  - earliest next command sampled the edge after commit.
- A read issued right after a commit returns the committed value (no hazard).
- cmd_err is high the cycle after the offending sample.

## Structure
- Shared package ulpi_pkg:
  - state enum.
  - TX CMD codes (CMD_IDLE 2'b00, CMD_TX 2'b01, CMD_REGW 2'b10, CMD_REGR 2'b11).
  - EXT_ADDR=6'h2F.
  - register addresses and reset defaults, also used by the link-side block.
- Sub-module ulpi_phy_regfile: alias decode, set/clear arithmetic, read mux. Combinational read, write on commit.

## Test plan
- Reset release → dir=1 for 16 cycles then 0; nxt=0 throughout.
- Link drives 0xC0 → nxt pulse, turnaround, data_out=0x24 with data_oe=1 for one cycle, dir low after. Repeat with 0xC1 → 0x04.
- Write 0x8A, data 0x00, stp → wr_strobe with wr_addr=0x0A, wr_data=0x00; subsequent read 0xCA returns 0x00.
- Set then clear on function control (default 0x41):
  - set 0x85 data 0x04 → 0x45.
  - clear 0x86 data 0x01 → 0x44.
  - read 0xC4 → 0x44.
- Commands 0x40, 0xEF, 0x01 → cmd_err pulse each; nxt and dir stay 0; registers unchanged.
- Reset asserted during RD_DATA and separately during WR_STP → dir=1, data_oe=0 immediately; after STARTUP, read 0xCA returns 0x06.
